aes_dec_iter_ctrl: RTL and testbench
====================================

# aes_dec_iter_ctrl

Iterative AES-128 decryption controller. Accepts one 128-bit ciphertext block and a fully expanded key schedule. Runs the initial AddRoundKey, then nine passes through a single `DecryptRound` instance and one pass through `LastDecryptRound`, one round per clock. Sits between the key-expansion logic and the system bus, and replaces the fully unrolled decrypt chain where area matters.

## Interface
Parameters:
- `NR`, 10: number of AES rounds. Only 10 (AES-128) is supported.

Ports:
- `clk`  in  1  single clock; all state updates on the rising edge.
- `reset_n`  in  1  asynchronous, active-low reset.
- `in_valid`  in  1  ciphertext block offered.
- `in_ready`  out  1  controller can accept a block.
- `in_data`  in  128  ciphertext, byte 0 in [127:120].
- `key_sched`  in  1408  expanded key. Round key i is `key_sched[1407-128*i -: 128]`; i=0 is the cipher key, i=10 is the last encryption key.
- `out_valid`  out  1  plaintext available.
- `out_ready`  in  1  consumer takes the plaintext.
- `out_data`  out  128  plaintext.
- `busy`  out  1  high in any state other than IDLE.
- `round_o`  out  4  current round-key index, for debug.

## Operation
- FSM has four states: IDLE, ROUND, LAST, DONE.
- **IDLE**: `in_ready`=1. On `in_valid`&&`in_ready`:
  - state register <= `in_data` ^ rk[10]
  - round <= 9
  - go to ROUND.
- **ROUND**: state <= DecryptRound(state, rk[round]).
  - If round==1, go to LAST.
  - Otherwise round <= round-1.
- **LAST**: state <= LastDecryptRound(state, rk[0]); round <= 0; go to DONE.
- **DONE**: `out_valid`=1 and `out_data`=state, held stable.
  - On `out_ready`, go to IDLE.
  - `in_ready`=0 in DONE. A new block cannot be accepted in the same cycle as the output handshake.
- Round-key select is a 4-bit index into 11 slices. Indices 11–15 are unreachable; if the index ever holds one of them, the mux returns rk[0].
- `out_data` is driven straight from the state register. It is only meaningful while `out_valid`=1.

## Timing
- Reset values: FSM=IDLE, state register=0, round=0, `in_ready`=1, `out_valid`=0, `busy`=0, `out_data`=0, `round_o`=0.
- Accept at edge E0. Rounds 9..1 execute on E1..E9. LAST executes on E10. `out_valid` is high from E10 onward.
- Latency is 10 cycles from accept to `out_valid`.
- Minimum period is 12 cycles per block: the zero-wait output handshake takes the cycle after E10, and the FSM is back in IDLE one cycle later.
- `out_ready` held high continuously: DONE lasts exactly one cycle.
- `out_ready` asserted while not in DONE: ignored.
- `in_valid` while busy: ignored. The upstream source must hold the block until `in_ready`.
- `reset_n` asserted mid-operation clears everything immediately. No partial result is ever flagged valid.
- Without `AES_DEC_KEY_LATCH_EN`, `key_sched` must stay stable from the accept edge through E10.

## Configuration
- Macro: `AES_DEC_KEY_LATCH_EN`.
- Defined:
  - A 1408-bit key register captures `key_sched` on the accept edge.
  - Rounds read the captured copy, so `key_sched` may change immediately after accept.
  - The key register resets to 0.
- Undefined:
  - No key register; rounds read `key_sched` live.
  - Area is about 1408 flops smaller.
  - The caller is responsible for keeping the key stable.

## Structure
- Shared package `aes_pkg` holds:
  - `AES_NR`=10
  - `AES_KS_W`=1408
  - FSM state encoding: IDLE=2'd0, ROUND=2'd1, LAST=2'd2, DONE=2'd3
  - round-key slice-index function
- One natural sub-module, `aes_rk_select`: combinational 11:1 mux of 128-bit round keys, indexed by round.
- Instantiates existing `DecryptRound` and `LastDecryptRound` once each; both are fed from the state register.

## Test plan
- FIPS-197 C.1 vector:
  - Stimulus: key 000102030405060708090a0b0c0d0e0f (schedule from existing key expansion), ciphertext 69c4e0d86a7b0430d8cdb78070b4c55a.
  - Required: `out_valid` exactly 10 cycles after accept; `out_data`=00112233445566778899aabbccddeeff.
- Back-to-back: `in_valid` and `out_ready` held high for 3 blocks -> accepts 12 cycles apart, all three outputs correct, `in_ready` low throughout each run.
- Output backpressure: `out_ready`=0 for 20 cycles after `out_valid` -> `out_data` is stable, `in_ready`=0, and a new `in_valid` is not accepted.
- Reset at E5 -> the next cycle shows all outputs at reset values; a following block decrypts correctly.
- With `AES_DEC_KEY_LATCH_EN`: corrupt `key_sched` one cycle after accept -> output is still 00112233445566778899aabbccddeeff.
- `round_o` sequence after accept -> 9,8,…,1, then 0 in LAST; `busy` high from E0 until the cycle after the output handshake.

Source files
------------

// File: rtl/aes_pkg.sv
// Shared definitions for the iterative AES-128 decryption slice.
//   AES_NR / AES_KS_W / AES_BLK_W : round count, key-schedule width, block width
//   aesFsm_t                      : controller state encoding
//   rkMsb / byteMsb               : slice-index helpers (round key i, state byte k)
//   xtime / gmul / gfInv / invSbox: GF(2^8) helpers used by the round primitives
package aes_pkg;

  localparam int AES_NR    = 10;
  localparam int AES_KS_W  = 1408;
  localparam int AES_BLK_W = 128;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ROUND = 2'd1,
    LAST  = 2'd2,
    DONE  = 2'd3
  } aesFsm_t;

  // MSB position of round key idx inside the packed schedule (rk[0] at the top).
  function automatic int rkMsb(input int idx);
    return AES_KS_W - 1 - AES_BLK_W * idx;
  endfunction

  // MSB position of state byte k (byte 0 at [127:120], column-major order).
  function automatic int byteMsb(input int k);
    return AES_BLK_W - 1 - 8 * k;
  endfunction

  function automatic logic [7:0] xtime(input logic [7:0] a);
    return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] acc;
    logic [7:0] x;
    acc = 8'h00;
    x   = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) acc = acc ^ x;
      x = xtime(x);
    end
    return acc;
  endfunction

  // Multiplicative inverse as a^254 = a^2 * a^4 * ... * a^128; maps 0 to 0.
  function automatic logic [7:0] gfInv(input logic [7:0] a);
    logic [7:0] p;
    logic [7:0] r;
    p = a;
    r = 8'h01;
    for (int i = 0; i < 7; i++) begin
      p = gmul(p, p);
      r = gmul(r, p);
    end
    return r;
  endfunction

  // Inverse S-box: undo the affine map (rotl 1,3,6 ^ 0x05), then invert.
  function automatic logic [7:0] invSbox(input logic [7:0] b);
    logic [7:0] t;
    t = {b[6:0], b[7]} ^ {b[4:0], b[7:5]} ^ {b[1:0], b[7:2]} ^ 8'h05;
    return gfInv(t);
  endfunction

endpackage

// File: rtl/DecryptRound.sv
// One full AES inverse-cipher round:
//   InvShiftRows -> InvSubBytes -> AddRoundKey -> InvMixColumns
// Ports: stateIn (128) current state, roundKey (128), stateOut (128) next state.
module DecryptRound
  import aes_pkg::*;
(
  input  logic [AES_BLK_W-1:0] stateIn,
  input  logic [AES_BLK_W-1:0] roundKey,
  output logic [AES_BLK_W-1:0] stateOut
);

  logic [AES_BLK_W-1:0] shifted;
  logic [AES_BLK_W-1:0] subbed;
  logic [AES_BLK_W-1:0] keyed;

  // Row r rotates right by r columns.
  always_comb begin
    shifted = '0;
    for (int c = 0; c < 4; c++)
      for (int r = 0; r < 4; r++)
        shifted[byteMsb(r + 4 * c) -: 8] = stateIn[byteMsb(r + 4 * ((c - r + 4) % 4)) -: 8];
  end

  always_comb begin
    subbed = '0;
    for (int k = 0; k < 16; k++)
      subbed[byteMsb(k) -: 8] = invSbox(shifted[byteMsb(k) -: 8]);
  end

  assign keyed = subbed ^ roundKey;

  always_comb begin
    stateOut = '0;
    for (int c = 0; c < 4; c++) begin
      stateOut[byteMsb(4 * c) -: 8] =
        gmul(keyed[byteMsb(4 * c) -: 8], 8'h0e) ^ gmul(keyed[byteMsb(4 * c + 1) -: 8], 8'h0b) ^
        gmul(keyed[byteMsb(4 * c + 2) -: 8], 8'h0d) ^ gmul(keyed[byteMsb(4 * c + 3) -: 8], 8'h09);
      stateOut[byteMsb(4 * c + 1) -: 8] =
        gmul(keyed[byteMsb(4 * c) -: 8], 8'h09) ^ gmul(keyed[byteMsb(4 * c + 1) -: 8], 8'h0e) ^
        gmul(keyed[byteMsb(4 * c + 2) -: 8], 8'h0b) ^ gmul(keyed[byteMsb(4 * c + 3) -: 8], 8'h0d);
      stateOut[byteMsb(4 * c + 2) -: 8] =
        gmul(keyed[byteMsb(4 * c) -: 8], 8'h0d) ^ gmul(keyed[byteMsb(4 * c + 1) -: 8], 8'h09) ^
        gmul(keyed[byteMsb(4 * c + 2) -: 8], 8'h0e) ^ gmul(keyed[byteMsb(4 * c + 3) -: 8], 8'h0b);
      stateOut[byteMsb(4 * c + 3) -: 8] =
        gmul(keyed[byteMsb(4 * c) -: 8], 8'h0b) ^ gmul(keyed[byteMsb(4 * c + 1) -: 8], 8'h0d) ^
        gmul(keyed[byteMsb(4 * c + 2) -: 8], 8'h09) ^ gmul(keyed[byteMsb(4 * c + 3) -: 8], 8'h0e);
    end
  end

endmodule

// File: rtl/LastDecryptRound.sv
// Final AES inverse-cipher round (no InvMixColumns):
//   InvShiftRows -> InvSubBytes -> AddRoundKey
// Ports: stateIn (128) current state, roundKey (128), stateOut (128) plaintext.
module LastDecryptRound
  import aes_pkg::*;
(
  input  logic [AES_BLK_W-1:0] stateIn,
  input  logic [AES_BLK_W-1:0] roundKey,
  output logic [AES_BLK_W-1:0] stateOut
);

  logic [AES_BLK_W-1:0] shifted;
  logic [AES_BLK_W-1:0] subbed;

  always_comb begin
    shifted = '0;
    for (int c = 0; c < 4; c++)
      for (int r = 0; r < 4; r++)
        shifted[byteMsb(r + 4 * c) -: 8] = stateIn[byteMsb(r + 4 * ((c - r + 4) % 4)) -: 8];
  end

  always_comb begin
    subbed = '0;
    for (int k = 0; k < 16; k++)
      subbed[byteMsb(k) -: 8] = invSbox(shifted[byteMsb(k) -: 8]);
  end

  assign stateOut = subbed ^ roundKey;

endmodule

// File: rtl/aes_rk_select.sv
// Combinational 11:1 round-key mux over the packed key schedule.
// Ports: keySched (1408) expanded key, rkIdx (4) round-key index,
//        roundKey (128) selected key. Indices 11..15 return rk[0].
module aes_rk_select
  import aes_pkg::*;
(
  input  logic [AES_KS_W-1:0]  keySched,
  input  logic [3:0]           rkIdx,
  output logic [AES_BLK_W-1:0] roundKey
);

  always_comb begin
    roundKey = keySched[rkMsb(0) -: AES_BLK_W];
    for (int i = 1; i <= AES_NR; i++)
      if (rkIdx == 4'(i)) roundKey = keySched[rkMsb(i) -: AES_BLK_W];
  end

endmodule

// File: rtl/aes_dec_iter_ctrl.sv
// Iterative AES-128 decryption controller: initial AddRoundKey on accept,
// nine DecryptRound passes, one LastDecryptRound pass, one round per clock.
// Ports:
//   clk, reset_n (async, active-low)
//   in_valid / in_ready / in_data[127:0]    ciphertext handshake
//   key_sched[1407:0]                       expanded key, rk[i] = [1407-128*i -: 128]
//   out_valid / out_ready / out_data[127:0] plaintext handshake
//   busy                                    high outside IDLE
//   round_o[3:0]                            current round-key index
// Build option: define AES_DEC_KEY_LATCH_EN to capture key_sched on accept so
// the caller may change it afterwards; otherwise rounds read key_sched live.
module aes_dec_iter_ctrl
  import aes_pkg::*;
#(
  parameter int NR = AES_NR
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [AES_BLK_W-1:0] in_data,
  input  logic [AES_KS_W-1:0]  key_sched,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [AES_BLK_W-1:0] out_data,
  output logic                 busy,
  output logic [3:0]           round_o
);

  aesFsm_t              fsmQ;
  aesFsm_t              fsmD;
  logic [AES_BLK_W-1:0] stateQ;
  logic [3:0]           roundQ;
  logic                 accept;
  logic [3:0]           rkIdx;
  logic [AES_KS_W-1:0]  keySrc;
  logic [AES_BLK_W-1:0] roundKey;
  logic [AES_BLK_W-1:0] roundOut;
  logic [AES_BLK_W-1:0] lastOut;

  assign accept = (fsmQ == IDLE) && in_valid;

  // The whitening step on accept uses the last encryption key.
  assign rkIdx = (fsmQ == IDLE) ? 4'(NR) : roundQ;

`ifdef AES_DEC_KEY_LATCH_EN
  logic [AES_KS_W-1:0] keyQ;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)    keyQ <= '0;
    else if (accept) keyQ <= key_sched;
  end

  // The register is not loaded until the accept edge, so IDLE still reads live.
  assign keySrc = (fsmQ == IDLE) ? key_sched : keyQ;
`else
  assign keySrc = key_sched;
`endif

  aes_rk_select uRkSel (
    .keySched (keySrc),
    .rkIdx    (rkIdx),
    .roundKey (roundKey)
  );

  DecryptRound uRound (
    .stateIn  (stateQ),
    .roundKey (roundKey),
    .stateOut (roundOut)
  );

  LastDecryptRound uLast (
    .stateIn  (stateQ),
    .roundKey (roundKey),
    .stateOut (lastOut)
  );

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) fsmQ <= IDLE;
    else          fsmQ <= fsmD;
  end

  always_comb begin
    fsmD = fsmQ;
    case (fsmQ)
      IDLE:    if (accept) fsmD = ROUND;
      ROUND:   if (roundQ == 4'd1) fsmD = LAST;
      LAST:    fsmD = DONE;
      DONE:    if (out_ready) fsmD = IDLE;
      default: fsmD = IDLE;
    endcase
  end

  // The index keeps decrementing on the final ROUND pass so LAST already
  // selects rk[0] and round_o reads 0 there.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      stateQ <= '0;
      roundQ <= '0;
    end else begin
      case (fsmQ)
        IDLE: begin
          if (accept) begin
            stateQ <= in_data ^ roundKey;
            roundQ <= 4'(NR - 1);
          end
        end
        ROUND: begin
          stateQ <= roundOut;
          roundQ <= roundQ - 4'd1;
        end
        LAST: begin
          stateQ <= lastOut;
          roundQ <= '0;
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    in_ready  = 1'b0;
    out_valid = 1'b0;
    busy      = 1'b1;
    case (fsmQ)
      IDLE: begin
        in_ready = 1'b1;
        busy     = 1'b0;
      end
      DONE:    out_valid = 1'b1;
      default: ;
    endcase
  end

  assign out_data = stateQ;
  assign round_o  = roundQ;

endmodule

// File: tb/tb_aes_dec_iter_ctrl.sv
// Self-checking bench for aes_dec_iter_ctrl: known-answer vectors from a
// table, per-cycle control trace, back-to-back, backpressure, mid-run reset,
// and (when AES_DEC_KEY_LATCH_EN is defined) key corruption after accept.
module tb_aes_dec_iter_ctrl;

  logic           clk = 1'b0;
  logic           reset_n;
  logic           in_valid;
  logic           in_ready;
  logic [127:0]   in_data;
  logic [1407:0]  key_sched;
  logic           out_valid;
  logic           out_ready;
  logic [127:0]   out_data;
  logic           busy;
  logic [3:0]     round_o;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  aes_dec_iter_ctrl dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .key_sched (key_sched),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .busy      (busy),
    .round_o   (round_o)
  );

  typedef struct {
    logic [127:0] key;
    logic [127:0] ct;
    logic [127:0] pt;
  } vec_t;

  typedef struct {
    logic [3:0] rnd;
    logic       bsy;
    logic       inRdy;
    logic       outVld;
  } ctl_t;

  vec_t vecs[5];
  ctl_t ctlTab[11];

  // ---------------- independent key-expansion model ----------------
  function automatic logic [7:0] tbXtime(input logic [7:0] a);
    return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] tbMul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] acc;
    logic [7:0] x;
    acc = 8'h00;
    x   = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) acc = acc ^ x;
      x = tbXtime(x);
    end
    return acc;
  endfunction

  function automatic logic [7:0] tbSbox(input logic [7:0] a);
    logic [7:0] inv;
    logic [7:0] p;
    p   = a;
    inv = 8'h01;
    for (int i = 0; i < 7; i++) begin
      p   = tbMul(p, p);
      inv = tbMul(inv, p);
    end
    return inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]} ^
           {inv[4:0], inv[7:5]} ^ {inv[3:0], inv[7:4]} ^ 8'h63;
  endfunction

  function automatic logic [1407:0] expandKey(input logic [127:0] key);
    logic [31:0]   w[44];
    logic [31:0]   t;
    logic [7:0]    rc;
    logic [1407:0] ks;
    rc = 8'h01;
    for (int i = 0; i < 4; i++) w[i] = key[127 - 32 * i -: 32];
    for (int i = 4; i < 44; i++) begin
      t = w[i - 1];
      if (i % 4 == 0) begin
        t  = {tbSbox(t[23:16]), tbSbox(t[15:8]), tbSbox(t[7:0]), tbSbox(t[31:24])} ^ {rc, 24'h0};
        rc = tbXtime(rc);
      end
      w[i] = w[i - 4] ^ t;
    end
    ks = '0;
    for (int i = 0; i < 44; i++) ks[1407 - 32 * i -: 32] = w[i];
    return ks;
  endfunction

  // ---------------- comparison helpers ----------------
  task automatic checkBit(input string name, input logic act, input logic exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %b, want %b", name, act, exp);
    end
  endtask

  task automatic checkInt(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d, want %0d", name, act, exp);
    end
  endtask

  task automatic checkWord(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h, want %h", name, act, exp);
    end
  endtask

  task automatic checkReset(input string tag);
    checkBit({tag, "_in_ready"}, in_ready, 1'b1);
    checkBit({tag, "_out_valid"}, out_valid, 1'b0);
    checkBit({tag, "_busy"}, busy, 1'b0);
    checkWord({tag, "_out_data"}, out_data, 128'h0);
    checkInt({tag, "_round_o"}, int'(round_o), 0);
  endtask

  task automatic traceCheck(input int n);
    if (n < 11) begin
      checkInt($sformatf("trace%0d_round_o", n), int'(round_o), int'(ctlTab[n].rnd));
      checkBit($sformatf("trace%0d_busy", n), busy, ctlTab[n].bsy);
      checkBit($sformatf("trace%0d_in_ready", n), in_ready, ctlTab[n].inRdy);
      checkBit($sformatf("trace%0d_out_valid", n), out_valid, ctlTab[n].outVld);
    end
  endtask

  // Offer a block at a negedge, wait (bounded) for out_valid, check latency and data.
  task automatic acceptBlock(input vec_t v, input bit trace, input bit corrupt, input string tag);
    int n;
    key_sched = expandKey(v.key);
    in_data   = v.ct;
    in_valid  = 1'b1;
    out_ready = 1'b0;
    checkBit({tag, "_in_ready_idle"}, in_ready, 1'b1);
    @(negedge clk);
    in_valid = 1'b0;
    in_data  = '0;
    if (corrupt) key_sched = ~key_sched;
    n = 0;
    while (!out_valid && n < 30) begin
      if (trace) traceCheck(n);
      @(negedge clk);
      n++;
    end
    if (trace) traceCheck(n);
    checkInt({tag, "_latency"}, n, 10);
    checkWord({tag, "_out_data"}, out_data, v.pt);
  endtask

  task automatic releaseOutput(input string tag);
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    checkBit({tag, "_valid_after_hs"}, out_valid, 1'b0);
    checkBit({tag, "_busy_after_hs"}, busy, 1'b0);
    checkBit({tag, "_ready_after_hs"}, in_ready, 1'b1);
  endtask

  task automatic backToBack();
    int  accCyc[3];
    int  acc;
    int  done;
    int  readyHigh;
    int  c;
    bit  accNow;
    acc       = 0;
    done      = 0;
    readyHigh = 0;
    c         = 0;
    accCyc    = '{0, 0, 0};
    key_sched = expandKey(vecs[2].key);
    in_data   = vecs[2].ct;
    in_valid  = 1'b1;
    out_ready = 1'b1;
    while (done < 3 && c < 60) begin
      accNow = in_ready && in_valid;
      if (in_ready) readyHigh++;
      if (out_valid) begin
        checkWord($sformatf("b2b_out%0d", done), out_data, vecs[2 + done].pt);
        done++;
      end
      if (accNow && acc < 3) begin
        accCyc[acc] = c;
        acc++;
      end
      @(negedge clk);
      c++;
      if (accNow) begin
        if (acc < 3) in_data = vecs[2 + acc].ct;
        else         in_valid = 1'b0;
      end
    end
    in_valid  = 1'b0;
    out_ready = 1'b0;
    checkInt("b2b_outputs", done, 3);
    checkInt("b2b_accepts", acc, 3);
    checkInt("b2b_ready_cycles", readyHigh, 3);
    checkInt("b2b_gap1", accCyc[1] - accCyc[0], 12);
    checkInt("b2b_gap2", accCyc[2] - accCyc[1], 12);
    checkBit("b2b_idle_busy", busy, 1'b0);
  endtask

  task automatic backpressure();
    acceptBlock(vecs[0], 1'b0, 1'b0, "bp");
    in_data  = vecs[1].ct;
    in_valid = 1'b1;
    for (int i = 0; i < 20; i++) begin
      checkBit($sformatf("bp%0d_out_valid", i), out_valid, 1'b1);
      checkWord($sformatf("bp%0d_out_data", i), out_data, vecs[0].pt);
      checkBit($sformatf("bp%0d_in_ready", i), in_ready, 1'b0);
      @(negedge clk);
    end
    in_valid = 1'b0;
    releaseOutput("bp");
  endtask

  task automatic midReset();
    key_sched = expandKey(vecs[0].key);
    in_data   = vecs[0].ct;
    in_valid  = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    repeat (5) @(negedge clk);
    checkBit("rst_busy_before", busy, 1'b1);
    checkInt("rst_round_before", int'(round_o), 4);
    reset_n = 1'b0;
    #1;
    checkReset("rst_async");
    @(negedge clk);
    checkReset("rst_next");
    reset_n = 1'b1;
    @(negedge clk);
    checkReset("rst_released");
    acceptBlock(vecs[0], 1'b0, 1'b0, "rst_after");
    releaseOutput("rst_after");
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    vecs[0] = '{128'h000102030405060708090a0b0c0d0e0f, 128'h69c4e0d86a7b0430d8cdb78070b4c55a,
                128'h00112233445566778899aabbccddeeff};
    vecs[1] = '{128'h2b7e151628aed2a6abf7158809cf4f3c, 128'h3925841d02dc09fbdc118597196a0b32,
                128'h3243f6a8885a308d313198a2e0370734};
    vecs[2] = '{128'h2b7e151628aed2a6abf7158809cf4f3c, 128'h3ad77bb40d7a3660a89ecaf32466ef97,
                128'h6bc1bee22e409f96e93d7e117393172a};
    vecs[3] = '{128'h2b7e151628aed2a6abf7158809cf4f3c, 128'hf5d3d58503b9699de785895a96fdbaaf,
                128'hae2d8a571e03ac9c9eb76fac45af8e51};
    vecs[4] = '{128'h2b7e151628aed2a6abf7158809cf4f3c, 128'h43b1cd7f598ece23881b00e3ed030688,
                128'h30c81c46a35ce411e5fbc1191a0a52ef};

    ctlTab[0]  = '{4'd9, 1'b1, 1'b0, 1'b0};
    ctlTab[1]  = '{4'd8, 1'b1, 1'b0, 1'b0};
    ctlTab[2]  = '{4'd7, 1'b1, 1'b0, 1'b0};
    ctlTab[3]  = '{4'd6, 1'b1, 1'b0, 1'b0};
    ctlTab[4]  = '{4'd5, 1'b1, 1'b0, 1'b0};
    ctlTab[5]  = '{4'd4, 1'b1, 1'b0, 1'b0};
    ctlTab[6]  = '{4'd3, 1'b1, 1'b0, 1'b0};
    ctlTab[7]  = '{4'd2, 1'b1, 1'b0, 1'b0};
    ctlTab[8]  = '{4'd1, 1'b1, 1'b0, 1'b0};
    ctlTab[9]  = '{4'd0, 1'b1, 1'b0, 1'b0};
    ctlTab[10] = '{4'd0, 1'b1, 1'b0, 1'b1};

    reset_n   = 1'b0;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    in_data   = '0;
    key_sched = '0;
    repeat (2) @(negedge clk);
    checkReset("reset_held");
    reset_n = 1'b1;
    @(negedge clk);
    checkReset("reset_released");

    for (int i = 0; i < 5; i++) begin
      acceptBlock(vecs[i], (i == 0), 1'b0, $sformatf("vec%0d", i));
      releaseOutput($sformatf("vec%0d", i));
    end

    backToBack();
    @(negedge clk);
    backpressure();
    midReset();

`ifdef AES_DEC_KEY_LATCH_EN
    acceptBlock(vecs[0], 1'b0, 1'b1, "latch");
    releaseOutput("latch");
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
